// File: rtl/aes_pkg.sv
// Shared AES constants and the occupancy encoding used by the
// inverse-cipher pipeline stages.
package aes_pkg;

    localparam int unsigned AES_NR      = 10;
    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_ROUND_W = 4;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_e;

endpackage

// File: rtl/ark_skid_buf.sv
// Two-entry elastic buffer (output register plus skid register) with a
// registered in_ready, so upstream never sees a combinational path from out_ready.
module ark_skid_buf
    import aes_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             accept;
    logic             drain;

    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != OccEmpty);
    assign out_data  = out_q;
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    always_comb begin
        occ_d  = occ_q;
        out_d  = out_q;
        skid_d = skid_q;
        case (occ_q)
            OccEmpty: begin
                if (accept) begin
                    occ_d = OccOne;
                    out_d = in_data;
                end
            end
            OccOne: begin
                if (accept && drain) begin
                    out_d = in_data;
                end else if (accept) begin
                    occ_d  = OccFull;
                    skid_d = in_data;
                end else if (drain) begin
                    occ_d = OccEmpty;
                end
            end
            OccFull: begin
                // in_ready is low here, so only a drain can happen
                if (drain) begin
                    occ_d = OccOne;
                    out_d = skid_q;
                end
            end
            default: occ_d = OccEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= OccEmpty;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            occ_q      <= occ_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= (occ_d != OccFull);
        end
    end

endmodule

// File: rtl/inv_addroundkey_stage.sv
// Inverse-cipher AddRoundKey stage: XORs the state with a stored round key.
// Define ARK_KEYREAD_EN to add a registered key-store read port.
module inv_addroundkey_stage
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_we,
    input  logic [AES_ROUND_W-1:0] key_waddr,
    input  logic [AES_STATE_W-1:0] key_wdata,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic [AES_ROUND_W-1:0] in_round,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic [AES_ROUND_W-1:0] out_round,
    output logic                   out_last,
`ifdef ARK_KEYREAD_EN
    input  logic [AES_ROUND_W-1:0] key_raddr,
    output logic [AES_STATE_W-1:0] key_rdata,
`endif
    output logic                   err_round
);

    localparam int unsigned            PAY_W  = AES_STATE_W + AES_ROUND_W + 1;
    localparam logic [AES_ROUND_W-1:0] NR_IDX = AES_ROUND_W'(NR);

    logic [AES_STATE_W-1:0] keys_q [NR+1];
    logic [AES_STATE_W-1:0] rd_key;
    logic [PAY_W-1:0]       in_payload;
    logic [PAY_W-1:0]       out_payload;
    logic                   err_q;

    // Out-of-range rounds fall through to the all-zero default key
    always_comb begin
        rd_key = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (in_round == AES_ROUND_W'(i)) begin
                rd_key = keys_q[i];
            end
        end
    end

    // Writes land at the edge, so a coincident acceptance still sees the old key
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                keys_q[i] <= '0;
            end
        end else if (key_we) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                if (key_waddr == AES_ROUND_W'(i)) begin
                    keys_q[i] <= key_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (in_valid && in_ready && (in_round > NR_IDX)) begin
            err_q <= 1'b1;
        end
    end

    assign err_round  = err_q;
    assign in_payload = {in_state ^ rd_key, in_round, (in_round == '0)};

    ark_skid_buf #(
        .WIDTH(PAY_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    assign {out_state, out_round, out_last} = out_payload;

`ifdef ARK_KEYREAD_EN
    logic [AES_STATE_W-1:0] rd_sel;

    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (key_raddr == AES_ROUND_W'(i)) begin
                rd_sel = keys_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_rdata <= '0;
        end else begin
            key_rdata <= rd_sel;
        end
    end
`endif

endmodule

// File: doc/inv_addroundkey_stage.md
INV_ADDROUNDKEY_STAGE -- requirements
Module: inv_addroundkey_stage

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds; the key store holds NR+1 round keys.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port key_we  input  1  round-key write strobe.
REQ-006 SHALL have port key_waddr  input  4  round-key index, 0..NR.
REQ-007 SHALL have port key_wdata  input  128  round key; bits [127:96] are column 0.
REQ-008 SHALL have port in_valid  input  1  upstream state valid.
REQ-009 SHALL have port in_ready  output  1  stage can accept a state.
REQ-010 SHALL have port in_state  input  128  state word, same column/byte packing as the inv_mixcolumn stage.
REQ-011 SHALL have port in_round  input  4  round index selecting the key.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  downstream (inv_mixcolumn path) can take the result.
REQ-014 SHALL have port out_state  output  128  in_state XOR round key.
REQ-015 SHALL have port out_round  output  4  round index carried with the data.
REQ-016 SHALL have port out_last  output  1  high when out_round==0, so the consumer bypasses inv_mixcolumn.
REQ-017 SHALL have port err_round  output  1  sticky flag for in_round>NR.

Function
REQ-018 SHALL complete a transfer on a port when valid and ready are both high at a rising edge.
REQ-019 SHALL present an accepted state on out_* exactly 1 cycle after acceptance when the output is empty.
REQ-020 SHALL hold out_state, out_round and out_last stable while out_valid=1 and out_ready=0.
REQ-021 SHALL use a 2-entry buffer (output register plus skid register) and drive in_ready=!skid_full from a register, never combinationally from out_ready.
REQ-022 SHALL track occupancy as EMPTY, ONE or FULL: accept-only moves up one; drain-only moves down one; accept+drain stays put.
REQ-023 SHALL, on simultaneous accept and drain in ONE, load the new state into the output register.
REQ-024 SHALL, in FULL, move the skid entry to the output register on drain and deassert in_ready until then.
REQ-025 SHALL preserve order; no transfer is dropped or duplicated.
REQ-026 SHALL read the round key combinationally at acceptance.
REQ-027 SHALL, when a key write to the same index coincides with an acceptance, use the old key for that transfer; the new key applies from the next cycle.
REQ-028 SHALL ignore key writes with key_waddr>NR.
REQ-029 SHALL accept in_round>NR, use an all-zero key for it, and set err_round until reset.

Reset
REQ-030 SHALL, on rst, set out_valid=0, in_ready=1, out_state=0, out_round=0, out_last=0, err_round=0 and occupancy EMPTY.
REQ-031 SHALL discard buffered data when rst asserts mid-operation.
REQ-032 SHALL clear the key store to zero on rst.

Configuration
REQ-033 SHALL, when ARK_KEYREAD_EN is defined, add port key_raddr (input 4) and key_rdata (output 128, registered, 1-cycle latency, zero for an out-of-range index); without the macro these ports do not exist and behaviour is otherwise identical.

Structure
REQ-034 SHALL take the NR default, AES_STATE_W=128 and the round-index width from the shared aes_pkg package.
REQ-035 SHALL contain one sub-module, ark_skid_buf, parameterised on payload width and holding the REQ-021..REQ-025 buffer logic.

Verification
REQ-036 SHALL cover: key 13111d7fe3944a17f307a78b4d2b30c5 written at index 10, in_state 69c4e0d86a7b0430d8cdb78070b4c55a with round 10 -> out_state 7ad5fda789ef4e272bca100b3d9ff59f, out_last=0, 1 cycle later.
REQ-037 SHALL cover: out_ready held 0 while 3 states are offered -> 2 accepted, in_ready=0, third held; out_ready=1 -> outputs drain in order.
REQ-038 SHALL cover: key index 3 rewritten in the same cycle a round-3 state is accepted -> the old key is applied.
REQ-039 SHALL cover: in_round=12 -> out_state equals in_state, err_round=1 until rst.
REQ-040 SHALL cover: rst asserted while FULL -> next cycle out_valid=0, in_ready=1, and the key store reads zero (via key_rdata when ARK_KEYREAD_EN is defined).
